// File: rtl/onehot_sel_find.sv
// One-hot AND-OR data selector plus lowest-set-bit finder, with optional
// registered copies of both results for pipelined consumers.
module onehot_sel_find #(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIND_WIDTH = 4,
    localparam int IDX_WIDTH = (FIND_WIDTH > 1) ? $clog2(FIND_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_WIDTH-1:0]  sel_in,
    input  logic [DATA_WIDTH-1:0] data_in [0:SEL_WIDTH-1],
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [FIND_WIDTH-1:0] find_in,
    output logic [IDX_WIDTH-1:0]  find_index,
    output logic                  find_valid,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] data_out_r,
    output logic [IDX_WIDTH-1:0]  find_index_r,
    output logic                  find_valid_r
);

    logic [SEL_WIDTH-1:0][DATA_WIDTH-1:0] w_term;
    logic [DATA_WIDTH-1:0]                w_data;
    logic [IDX_WIDTH-1:0]                 w_idx;
    logic                                 w_vld;

    // Multi-hot selects are legal: overlapping terms simply OR together.
    for (genvar k = 0; k < SEL_WIDTH; k++) begin : g_term
        assign w_term[k] = {DATA_WIDTH{sel_in[k]}} & data_in[k];
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            w_data = w_data | w_term[k];
        end
    end

    // Scan from the top down so the lowest set bit wins last.
    always_comb begin
        w_idx = '0;
        for (int k = FIND_WIDTH - 1; k >= 0; k--) begin
            if (find_in[k]) begin
                w_idx = IDX_WIDTH'(k);
            end
        end
    end

    assign w_vld      = |find_in;
    assign data_out   = w_data;
    assign find_index = w_idx;
    assign find_valid = w_vld;

    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_idx  <= '0;
            r_vld  <= 1'b0;
        end else if (en) begin
            r_data <= w_data;
            r_idx  <= w_idx;
            r_vld  <= w_vld;
        end
    end

    assign data_out_r   = r_data;
    assign find_index_r = r_idx;
    assign find_valid_r = r_vld;

endmodule

// File: tb/tb_onehot_sel_find.sv
// Bench for onehot_sel_find: directed vector table, pipeline/reset sequences,
// and exhaustive randomized-data sweep against a behavioural model.
module tb_onehot_sel_find;
    localparam int SW = 4, DW = 8, FW = 4, IW = 2, FW5 = 5, IW5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en;
    logic [SW-1:0] sel_in;
    logic [DW-1:0] data_in [0:SW-1];
    logic [DW-1:0] data_out, data_out_r;
    logic [FW-1:0] find_in;
    logic [IW-1:0] find_index, find_index_r;
    logic          find_valid, find_valid_r;

    logic [FW5-1:0] find5_in;
    logic [DW-1:0]  d5, d5_r;
    logic [IW5-1:0] idx5, idx5_r;
    logic           vld5, vld5_r;

    onehot_sel_find #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .FIND_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .sel_in(sel_in), .data_in(data_in), .data_out(data_out),
        .find_in(find_in), .find_index(find_index), .find_valid(find_valid), .en(en),
        .data_out_r(data_out_r), .find_index_r(find_index_r), .find_valid_r(find_valid_r));

    onehot_sel_find #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .FIND_WIDTH(FW5)) dut5 (
        .clk(clk), .rst(rst), .sel_in(sel_in), .data_in(data_in), .data_out(d5),
        .find_in(find5_in), .find_index(idx5), .find_valid(vld5), .en(en),
        .data_out_r(d5_r), .find_index_r(idx5_r), .find_valid_r(vld5_r));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: OR of every selected element.
    function automatic logic [DW-1:0] m_sel(input logic [SW-1:0] s);
        logic [DW-1:0] acc = '0;
        for (int k = 0; k < SW; k++) if (s[k]) acc = acc | data_in[k];
        return acc;
    endfunction

    // Reference: shift right until bit 0 is set, counting the shifts.
    function automatic int m_idx(input int unsigned v);
        int n = 0;
        if (v == 0) return 0;
        while ((v & 1) == 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    typedef struct {
        logic [SW-1:0] sel;
        logic [FW-1:0] fnd;
        logic [DW-1:0] exp_d;
        int            exp_i;
        logic          exp_v;
    } vec_t;

    vec_t vecs [6];
    logic [DW-1:0] exp_rd;
    int            exp_ri;
    logic          exp_rv;

    initial begin
        vecs[0] = '{4'b0100, 4'b1000, 8'h44, 3, 1'b1};
        vecs[1] = '{4'b0001, 4'b0110, 8'h11, 1, 1'b1};
        vecs[2] = '{4'b0000, 4'b1111, 8'h00, 0, 1'b1};
        vecs[3] = '{4'b1010, 4'b0000, 8'hAA, 0, 1'b0};
        vecs[4] = '{4'b1111, 4'b0001, 8'hFF, 0, 1'b1};
        vecs[5] = '{4'b1000, 4'b0100, 8'h88, 2, 1'b1};

        rst = 1'b1; en = 1'b0; sel_in = '0; find_in = '0; find5_in = '0;
        data_in[0] = 8'h11; data_in[1] = 8'h22; data_in[2] = 8'h44; data_in[3] = 8'h88;
        tick();
        chk("reset data_out_r", 32'(data_out_r), 0);
        chk("reset find_index_r", 32'(find_index_r), 0);
        chk("reset find_valid_r", 32'(find_valid_r), 0);
        chk("reset dut5 idx_r", 32'(idx5_r), 0);

        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel_in = vecs[i].sel; find_in = vecs[i].fnd;
            #1;
            chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_d));
            chk($sformatf("vec%0d find_index", i), 32'(find_index), 32'(vecs[i].exp_i));
            chk($sformatf("vec%0d find_valid", i), 32'(find_valid), 32'(vecs[i].exp_v));
        end

        // Pipeline load then hold.
        tick();
        en = 1'b1; sel_in = 4'b0010; find_in = 4'b0100;
        tick();
        chk("pipe data_out_r", 32'(data_out_r), 32'h22);
        chk("pipe find_index_r", 32'(find_index_r), 2);
        chk("pipe find_valid_r", 32'(find_valid_r), 1);
        en = 1'b0; sel_in = 4'b1000; find_in = 4'b0001;
        tick();
        chk("hold data_out_r", 32'(data_out_r), 32'h22);
        chk("hold find_index_r", 32'(find_index_r), 2);
        chk("hold find_valid_r", 32'(find_valid_r), 1);
        chk("hold comb data_out", 32'(data_out), 32'h88);
        chk("hold comb find_index", 32'(find_index), 0);

        // Reset overrides en; comb path keeps tracking during reset.
        rst = 1'b1; en = 1'b1;
        tick();
        chk("rst data_out_r", 32'(data_out_r), 0);
        chk("rst find_index_r", 32'(find_index_r), 0);
        chk("rst find_valid_r", 32'(find_valid_r), 0);
        sel_in = 4'b0100; find_in = 4'b0010;
        #1;
        chk("rst comb data_out", 32'(data_out), 32'h44);
        chk("rst comb find_index", 32'(find_index), 1);
        chk("rst comb find_valid", 32'(find_valid), 1);
        rst = 1'b0;
        tick();
        chk("reload data_out_r", 32'(data_out_r), 32'h44);
        chk("reload find_index_r", 32'(find_index_r), 1);
        chk("reload find_valid_r", 32'(find_valid_r), 1);
        exp_rd = 8'h44; exp_ri = 1; exp_rv = 1'b1;

        // Exhaustive codes, random data, random en.
        for (int s = 0; s < 16; s++) begin
            for (int f = 0; f < 16; f++) begin
                for (int k = 0; k < SW; k++) data_in[k] = DW'($urandom);
                sel_in = SW'(s); find_in = FW'(f); en = 1'($urandom);
                #1;
                chk("rand data_out", 32'(data_out), 32'(m_sel(SW'(s))));
                chk("rand find_index", 32'(find_index), 32'(m_idx(f)));
                chk("rand find_valid", 32'(find_valid), 32'(f != 0));
                if (en) begin
                    exp_rd = m_sel(SW'(s)); exp_ri = m_idx(f); exp_rv = (f != 0);
                end
                tick();
                chk("rand data_out_r", 32'(data_out_r), 32'(exp_rd));
                chk("rand find_index_r", 32'(find_index_r), 32'(exp_ri));
                chk("rand find_valid_r", 32'(find_valid_r), 32'(exp_rv));
            end
        end

        // Non-power-of-2 finder width.
        for (int v = 0; v < 32; v++) begin
            find5_in = FW5'(v);
            #1;
            chk("fw5 find_index", 32'(idx5), 32'(m_idx(v)));
            chk("fw5 find_valid", 32'(vld5), 32'(v != 0));
        end
        en = 1'b1; find5_in = 5'b10000;
        tick();
        chk("fw5 find_index_r", 32'(idx5_r), 4);
        chk("fw5 find_valid_r", 32'(vld5_r), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
